// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources.
// Issues one start pulse per grant, tracks the frame via tx_ready, then enforces a stop-bit guard.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GUARD_CYCLES = 2084,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     err
);

    localparam int OWN_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (GUARD_CYCLES > ACK_TIMEOUT) ? GUARD_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        GUARD
    } state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic [OWN_W-1:0]   owner_q;
    logic               err_q;
    logic [OWN_W-1:0]   rr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               win_found;
    logic [OWN_W-1:0]   win_idx;
    logic [OWN_W-1:0]   cand;
    logic [N_REQ-1:0]   gnt_d;
    logic [7:0]         tx_data_d;

    // Scan starts one past the last winner so the previous owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OWN_W'((int'(rr_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_d     = '0;
        tx_data_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == OWN_W'(i)) begin
                gnt_d[i]  = 1'b1;
                tx_data_d = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            err_q      <= 1'b0;
            rr_q       <= OWN_W'(N_REQ - 1);
            cnt_q      <= '0;
        end else begin
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_ready && win_found) begin
                        tx_data_q  <= tx_data_d;
                        tx_start_q <= 1'b1;
                        gnt_q      <= gnt_d;
                        owner_q    <= win_idx;
                        rr_q       <= win_idx;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!tx_ready) begin
                        state_q <= WAIT_HIGH;
                    end else if (cnt_q == ACK_LAST) begin
                        // The transmitter never took the byte; it is dropped, not retried.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (tx_ready) begin
                        if (GUARD_CYCLES == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= GUARD_LOAD;
                            state_q <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    // tx_ready rises at the start of the stop bit, so wait it out here.
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios push expected grants,
// a negedge monitor pops and checks them whenever a grant appears.
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int GUARD = 16;
    localparam int ACK   = 8;
    localparam int BIT   = 4;
    localparam int FRAME = 9 * BIT;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic [N_REQ-1:0] req      = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0] gnt;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_ready = 1'b1;
    logic             busy;
    logic [1:0]       owner;
    logic             err;

    int n_chk = 0;
    int n_fail = 0;
    int n_err = 0;
    int cyc = 0;
    int ucnt = 0;
    bit force_rdy = 1'b0;
    logic [7:0] exp_hold = 8'h00;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .GUARD_CYCLES(GUARD),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_ready(tx_ready),
        .busy(busy),
        .owner(owner),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: not reset; ready low for start+8 data bits, high again at the stop bit.
    always @(posedge clk) begin
        if (force_rdy) begin
            tx_ready <= 1'b1;
        end else if (tx_ready && tx_start) begin
            tx_ready <= 1'b0;
            ucnt     <= FRAME - 1;
        end else if (!tx_ready) begin
            if (ucnt == 0) tx_ready <= 1'b1;
            else ucnt <= ucnt - 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_hold = 8'h00;
        end else begin
            if (err) n_err++;
            if (gnt != '0 || tx_start) begin
                chk("start_with_gnt", int'(tx_start), int'(gnt != '0));
                chk("ready_at_start", int'(tx_ready), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", int'(gnt), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_onehot", int'(gnt), 1 << e.idx);
                    chk("tx_data", int'(tx_data), int'(e.data));
                    chk("owner", int'(owner), e.idx);
                    exp_hold = e.data;
                end
            end else begin
                chk("tx_data_hold", int'(tx_data), int'(exp_hold));
            end
        end
    end

    task automatic wait_gnt(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (gnt != '0);
        end
        chk({name, "_seen"}, int'(seen), 1);
    endtask

    task automatic wait_ready(input logic val, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (tx_ready == val);
        end
        chk({name, "_seen"}, int'(seen), 1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        chk({name, "_seen"}, int'(seen), 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_gnt"}, int'(gnt), 0);
        chk({name, "_tx_data"}, int'(tx_data), 0);
        chk({name, "_tx_start"}, int'(tx_start), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_owner"}, int'(owner), 0);
        chk({name, "_err"}, int'(err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int m;
        int g;
        bit seen;
        bit bad;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // T1: single byte from requester 0
        req_data[7:0] = 8'hA5;
        push_exp(0, 8'hA5);
        req = 4'b0001;
        wait_gnt("t1_gnt");
        chk("t1_busy", int'(busy), 1);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_start_1cyc", int'(tx_start), 0);
        chk("t1_gnt_1cyc", int'(gnt), 0);
        wait_ready(1'b0, "t1_ready_low");
        wait_ready(1'b1, "t1_ready_high");
        k = cyc;
        chk("t1_busy_in_guard", int'(busy), 1);
        wait_idle("t1_idle");
        chk("t1_busy_end", cyc - k, GUARD + 1);

        // Reset so requester 0 wins first again
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // T2: all four requesting, eight frames
        req_data = {8'h30, 8'h20, 8'h10, 8'h00};
        push_exp(0, 8'h00); push_exp(1, 8'h10); push_exp(2, 8'h20); push_exp(3, 8'h30);
        push_exp(0, 8'h01); push_exp(1, 8'h11); push_exp(2, 8'h21); push_exp(3, 8'h31);
        req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            wait_gnt("t2_gnt");
            g = 0;
            for (int i = 0; i < N_REQ; i++) if (gnt[i]) g = i;
            req_data[8*g +: 8] = req_data[8*g +: 8] + 8'd1;
        end
        req = 4'b0000;
        wait_idle("t2_idle");

        // T3: guard spacing between consecutive starts
        req_data[7:0]  = 8'h3C;
        req_data[15:8] = 8'hC3;
        push_exp(0, 8'h3C);
        push_exp(1, 8'hC3);
        req = 4'b0011;
        wait_gnt("t3_gnt0");
        req = 4'b0010;
        wait_ready(1'b0, "t3_ready_low");
        wait_ready(1'b1, "t3_ready_high");
        k = cyc;
        wait_gnt("t3_gnt1");
        m = cyc;
        // k+1 is the edge that samples ready high, m the edge that raises tx_start
        chk("t3_guard_gap", m - (k + 1), GUARD + 1);
        req = 4'b0000;
        wait_idle("t3_idle");

        // T4: transmitter never acknowledges
        force_rdy = 1'b1;
        req_data[23:16] = 8'h5A;
        req_data[7:0]   = 8'h77;
        push_exp(2, 8'h5A);
        req = 4'b0101;
        wait_gnt("t4_gnt");
        k = cyc;
        req_data[23:16] = 8'h5B;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = err;
        end
        chk("t4_err_seen", int'(seen), 1);
        chk("t4_err_delay", cyc - k, ACK);
        chk("t4_busy_after_err", int'(busy), 0);
        push_exp(0, 8'h77);
        push_exp(2, 8'h5B);
        force_rdy = 1'b0;
        wait_gnt("t4_regrant");
        chk("t4_err_1cyc", int'(err), 0);
        req = 4'b0100;
        wait_gnt("t4_third");
        req = 4'b0000;
        wait_idle("t4_idle");

        // T5: reset while the frame is on the line
        req_data[15:8] = 8'h96;
        push_exp(1, 8'h96);
        req = 4'b0010;
        wait_gnt("t5_gnt");
        req = 4'b0000;
        wait_ready(1'b0, "t5_ready_low");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t5_async");
        req_data[7:0]  = 8'h44;
        req_data[15:8] = 8'h55;
        req = 4'b0011;
        push_exp(0, 8'h44);
        push_exp(1, 8'h55);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100 && !tx_ready; i++) begin
            @(negedge clk);
            if (tx_start || gnt != '0) bad = 1'b1;
        end
        chk("t5_no_start_while_ready_low", int'(bad), 0);
        chk("t5_ready_back", int'(tx_ready), 1);
        wait_gnt("t5_first");
        req = 4'b0010;
        wait_gnt("t5_second");
        req = 4'b0000;
        wait_idle("t5_idle");

        // T6: a one-cycle request while busy must not be served
        req_data[7:0] = 8'h0F;
        push_exp(0, 8'h0F);
        req = 4'b0001;
        wait_gnt("t6_gnt");
        req = 4'b0000;
        repeat (5) @(negedge clk);
        req_data[23:16] = 8'hEE;
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_idle("t6_idle");
        repeat (60) @(negedge clk);
        chk("t6_busy_stays_low", int'(busy), 0);
        chk("t6_no_extra_frame", exp_q.size(), 0);

        chk("err_pulse_count", n_err, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
